// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx -- byte-wide asynchronous serial transmitter (8 data bits, LSB
// first, optional even parity, one stop bit).
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   PARITY_EN    : 1 appends an even-parity bit after the data bits
//
// Ports
//   clk          : clock, all state changes on its rising edge
//   reset        : asynchronous, active-high reset
//   data_in      : byte to send, latched when a request is taken
//   trans_enable : transmit request; only a rising edge starts a frame
//   serial_out   : registered serial line, idle high
//   char_sent    : one-cycle pulse in the first IDLE cycle after STOP
//   busy         : high while a frame is in progress
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       trans_enable,
  output logic       serial_out,
  output logic       char_sent,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic        en_q;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        sent_q, sent_d;
  logic        busy_q, busy_d;

  logic req;
  logic bit_end;

  // Only a rising edge of trans_enable is a request; holding it high does
  // not retrigger.
  assign req     = trans_enable & ~en_q;
  assign bit_end = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sent_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          shift_d = data_in;
          par_d   = ^data_in;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;   // wraps 7->0 on the last data bit
          if (idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          sent_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line and busy are decoded from the next state so the registered
  // outputs line up with the state register (START appears one clock
  // after the request).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 1'b1;   // a level already high at release is not a request
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= trans_enable;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  assign serial_out = tx_q;
  assign char_sent  = sent_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  logic            clk;
  logic            reset;
  logic [1:0]      te;
  logic [1:0][7:0] din;
  logic [1:0]      so;
  logic [1:0]      cs;
  logic [1:0]      bz;

  int nchecks = 0;
  int nerrs   = 0;

  // unit 0: no parity, unit 1: even parity; both 4 clocks per bit
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .trans_enable(te[0]),
    .serial_out(so[0]), .char_sent(cs[0]), .busy(bz[0]));

  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .trans_enable(te[1]),
    .serial_out(so[1]), .char_sent(cs[1]), .busy(bz[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Start a frame in the current cycle and check every cycle up to and
  // including the char_sent cycle. bits[0] is the start bit.
  // mode 0: drop te after the request
  // mode 1: second rising edge mid-frame with different data
  // mode 2: hold te high throughout
  // mode 3: change data_in to 8'hFF one cycle after the request
  task automatic run_frame(input int u, input logic [7:0] data,
                           input logic [10:0] bits, input int nbits,
                           input int mode);
    din[u] = data;
    te[u]  = 1'b1;
    for (int c = 1; c <= nbits * 4 + 1; c++) begin
      @(posedge clk); #1;
      if (c <= nbits * 4) begin
        chk($sformatf("line u%0d c%0d", u, c), so[u], bits[4'((c - 1) / 4)]);
        chk($sformatf("busy u%0d c%0d", u, c), bz[u], 1'b1);
        chk($sformatf("char_sent low u%0d c%0d", u, c), cs[u], 1'b0);
      end else begin
        chk($sformatf("idle line u%0d", u), so[u], 1'b1);
        chk($sformatf("busy end u%0d", u), bz[u], 1'b0);
        chk($sformatf("char_sent pulse u%0d c%0d", u, c), cs[u], 1'b1);
      end
      if (c == 1 && mode != 2) te[u] = 1'b0;
      if (c == 1 && mode == 3) din[u] = 8'hFF;
      if (c == 10 && mode == 1) begin te[u] = 1'b1; din[u] = 8'h3C; end
      if (c == 14 && mode == 1) te[u] = 1'b0;
    end
  endtask

  typedef struct {
    int          unit;
    logic [7:0]  data;
    logic [10:0] bits;
    int          nbits;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // {stop, [parity], data MSB..LSB, start} -> sent LSB of this word first
    tbl[0] = '{0, 8'hA5, {2'b01, 8'hA5, 1'b0}, 10};
    tbl[1] = '{0, 8'h00, {2'b01, 8'h00, 1'b0}, 10};
    tbl[2] = '{0, 8'hFF, {2'b01, 8'hFF, 1'b0}, 10};
    tbl[3] = '{1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11};
    tbl[4] = '{1, 8'h03, {1'b1, 1'b0, 8'h03, 1'b0}, 11};
    tbl[5] = '{1, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    tbl[6] = '{1, 8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 11};

    reset = 1'b1;
    te    = 2'b01;   // unit 0 request level already high across reset
    din   = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset line u%0d", u), so[u], 1'b1);
      chk($sformatf("reset busy u%0d", u), bz[u], 1'b0);
      chk($sformatf("reset char_sent u%0d", u), cs[u], 1'b0);
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("te high at release busy", bz[0], 1'b0);
      chk("te high at release line", so[0], 1'b1);
    end
    te = 2'b00;
    @(posedge clk); #1;

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].unit, tbl[i].data, tbl[i].bits, tbl[i].nbits, 0);
      @(posedge clk); #1;
      chk($sformatf("char_sent one cycle v%0d", i), cs[tbl[i].unit], 1'b0);
    end

    // request in the char_sent cycle starts the next frame at the next edge
    run_frame(0, 8'hA5, {2'b01, 8'hA5, 1'b0}, 10, 0);
    run_frame(0, 8'h5A, {2'b01, 8'h5A, 1'b0}, 10, 0);
    @(posedge clk); #1;
    chk("b2b char_sent drop", cs[0], 1'b0);

    // held high: exactly one frame over 100 cycles
    run_frame(0, 8'hC3, {2'b01, 8'hC3, 1'b0}, 10, 2);
    for (int c = 0; c < 59; c++) begin
      @(posedge clk); #1;
      chk("held te no refire busy", bz[0], 1'b0);
      chk("held te no char_sent", cs[0], 1'b0);
    end
    te[0] = 1'b0;
    @(posedge clk); #1;

    // second edge mid-frame is ignored
    run_frame(0, 8'hA5, {2'b01, 8'hA5, 1'b0}, 10, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("ignored req no frame", bz[0], 1'b0);
    end

    // data_in change after latch has no effect
    run_frame(0, 8'h12, {2'b01, 8'h12, 1'b0}, 10, 3);
    @(posedge clk); #1;

    // reset during DATA bit 3 (frame cycles 17..20; A5 bit3 = 0)
    din[0] = 8'hA5;
    te[0]  = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 1) te[0] = 1'b0;
    end
    chk("pre-abort line", so[0], 1'b0);
    chk("pre-abort busy", bz[0], 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("abort line async", so[0], 1'b1);
    chk("abort busy async", bz[0], 1'b0);
    chk("abort char_sent", cs[0], 1'b0);
    te[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      chk("post-abort char_sent", cs[0], 1'b0);
      chk("post-abort busy", bz[0], 1'b0);
      chk("post-abort line", so[0], 1'b1);
    end
    te[0] = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
